// File: rtl/trig_pkg.sv
// -----------------------------------------------------------------------------
// trig_pkg
// Shared definitions for the trig_pipe sine/cosine generator.
//   quadrant_e   : which quarter-turn an angle falls in
//   fold_t       : sign and folded quarter-wave offset of an angle
//   quarterTurn  : Q = 2^(ANGLE_W-2), the number of phase LSBs per quarter turn
//   fracBits     : F = ANGLE_W-2-LUT_AW, offset bits below the table index
//   fixedOne     : 1.0 in signed 2.(OUT_W-2) fixed point
//   foldAngle    : maps a full-turn angle onto the first quadrant
// -----------------------------------------------------------------------------
package trig_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  typedef struct packed {
    logic        neg;
    logic [31:0] offset;
  } fold_t;

  function automatic int quarterTurn(input int angleW);
    return 1 << (angleW - 2);
  endfunction

  function automatic int fracBits(input int angleW, input int lutAw);
    return angleW - 2 - lutAw;
  endfunction

  function automatic longint fixedOne(input int outW);
    return longint'(1) << (outW - 2);
  endfunction

  // Odd quadrants read the table backwards (Q - r); the lower half-turn is
  // positive, the upper half-turn negative. Q - r can reach Q itself, which
  // is why the caller keeps ANGLE_W-1 bits of the offset.
  function automatic fold_t foldAngle(input logic [31:0] angle, input int angleW);
    fold_t       res;
    quadrant_e   quad;
    logic [31:0] qt;
    logic [31:0] r;
    qt         = 32'(quarterTurn(angleW));
    quad       = quadrant_e'(2'((angle >> (angleW - 2)) & 32'd3));
    r          = angle & (qt - 32'd1);
    res.neg    = (quad == Q2) || (quad == Q3);
    res.offset = ((quad == Q1) || (quad == Q3)) ? (qt - r) : r;
    return res;
  endfunction

endpackage

// File: rtl/quarter_sin_rom.sv
// -----------------------------------------------------------------------------
// quarter_sin_rom
// Synchronous quarter-wave sine ROM with 2^LUT_AW+1 entries of OUT_W bits,
// S[k] = round(sin(pi/2 * k / 2^LUT_AW) * 2^(OUT_W-2)); the last entry is 1.0.
// Contents are computed at elaboration by a constant integer function, so the
// table tracks LUT_AW/OUT_W without any external generator.
// Ports:
//   Clk      in   clock
//   en_i     in   read enable (holds both outputs when low)
//   addrA_i  in   read address, port A
//   addrB_i  in   read address, port B (ignored when HAS_B = 0)
//   dataA_o  out  registered table entry, port A
//   dataB_o  out  registered table entry, port B (zero when HAS_B = 0)
// -----------------------------------------------------------------------------
module quarter_sin_rom
  import trig_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 16,
  parameter bit HAS_B  = 1'b1
) (
  input  logic                    Clk,
  input  logic                    en_i,
  input  logic [LUT_AW:0]         addrA_i,
  input  logic [LUT_AW:0]         addrB_i,
  output logic signed [OUT_W-1:0] dataA_o,
  output logic signed [OUT_W-1:0] dataB_o
);

  localparam int     DEPTH       = (1 << LUT_AW) + 1;
  // pi/2 in Q30
  localparam longint HALF_PI_Q30 = 64'sd1686629713;

  // Taylor series of sin in Q30; the residual error is far below 1e-4 LSB,
  // so the final rounding matches the real-valued definition.
  function automatic logic signed [OUT_W-1:0] sinEntry(input int k);
    longint x;
    longint x2;
    longint term;
    longint acc;
    if (k >= (1 << LUT_AW)) begin
      return OUT_W'(fixedOne(OUT_W));
    end
    x    = (HALF_PI_Q30 * longint'(k)) >>> LUT_AW;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    return OUT_W'(((acc <<< (OUT_W - 2)) + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic signed [OUT_W-1:0] romTable [DEPTH];
  logic signed [OUT_W-1:0] dataA_q;
  logic signed [OUT_W-1:0] dataB_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign romTable[g] = sinEntry(g);
  end

  always_ff @(posedge Clk) begin
    if (en_i) begin
      dataA_q <= romTable[addrA_i];
    end
  end

  if (HAS_B) begin : g_portB
    always_ff @(posedge Clk) begin
      if (en_i) begin
        dataB_q <= romTable[addrB_i];
      end
    end
  end else begin : g_noPortB
    assign dataB_q = '0;
  end

  assign dataA_o = dataA_q;
  assign dataB_o = dataB_q;

endmodule

// File: rtl/trig_pipe.sv
// -----------------------------------------------------------------------------
// trig_pipe
// Three-stage pipelined sin/cos generator using a quarter-wave table with
// quadrant folding. Results are signed 2.(OUT_W-2) fixed point.
//   S1: decode/fold   S2: table read   S3: interpolate/negate (output register)
// A single global stall (advance = ~out_valid | out_ready) moves all stages.
// Build option: define TRIG_INTERP_EN for linear interpolation between S[k]
// and S[k+1]; otherwise the result is S[k] and the second table reads and
// multipliers are absent. Latency is 3 cycles either way.
// Ports:
//   Clk        in   clock
//   Reset_n    in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  request accepted when in_valid & in_ready
//   in_angle   in   full-turn phase, 1 LSB = 2*pi/2^ANGLE_W
//   in_tag     in   opaque request tag
//   out_valid  out  result present
//   out_ready  in   consumer takes result when out_valid & out_ready
//   out_sin    out  sin(angle)
//   out_cos    out  cos(angle)
//   out_tag    out  tag of the result
// -----------------------------------------------------------------------------
module trig_pipe
  import trig_pkg::*;
#(
  parameter int ANGLE_W = 12,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 16,
  parameter int TAG_W   = 4
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ANGLE_W-1:0]      in_angle,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_sin,
  output logic signed [OUT_W-1:0] out_cos,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int QTURN = quarterTurn(ANGLE_W);
  localparam int F     = fracBits(ANGLE_W, LUT_AW);
  localparam int FW    = (F > 0) ? F : 1;
  localparam int KW    = LUT_AW + 1;
  localparam int OW    = ANGLE_W - 1;
`ifdef TRIG_INTERP_EN
  localparam bit INTERP = 1'b1;
`else
  localparam bit INTERP = 1'b0;
`endif

  logic advance;

  // ---------------- S1: decode / fold ----------------
  logic [ANGLE_W-1:0] cosAngle;
  fold_t              sinFold;
  fold_t              cosFold;
  logic [OW-1:0]      sinOff;
  logic [OW-1:0]      cosOff;
  logic [KW-1:0]      sinK_d;
  logic [KW-1:0]      cosK_d;
  logic [FW-1:0]      sinF_d;
  logic [FW-1:0]      cosF_d;

  logic               valid1_q;
  logic [TAG_W-1:0]   tag1_q;
  logic               sinNeg1_q;
  logic               cosNeg1_q;
  logic [KW-1:0]      sinK1_q;
  logic [KW-1:0]      cosK1_q;

  // cos(a) = sin(a + Q); the add wraps modulo a full turn
  assign cosAngle = in_angle + ANGLE_W'(QTURN);
  assign sinFold  = foldAngle(32'(in_angle), ANGLE_W);
  assign cosFold  = foldAngle(32'(cosAngle), ANGLE_W);
  assign sinOff   = sinFold.offset[OW-1:0];
  assign cosOff   = cosFold.offset[OW-1:0];

  if (F > 0) begin : g_frac
    assign sinK_d = sinOff[OW-1:F];
    assign cosK_d = cosOff[OW-1:F];
    assign sinF_d = sinOff[F-1:0];
    assign cosF_d = cosOff[F-1:0];
  end else begin : g_noFrac
    assign sinK_d = sinOff;
    assign cosK_d = cosOff;
    assign sinF_d = '0;
    assign cosF_d = '0;
  end

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Stage valid bits are the only pipeline state that must be reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid1_q <= 1'b0;
    end else if (advance) begin
      valid1_q <= in_valid;
    end
  end

  always_ff @(posedge Clk) begin
    if (advance) begin
      tag1_q    <= in_tag;
      sinNeg1_q <= sinFold.neg;
      cosNeg1_q <= cosFold.neg;
      sinK1_q   <= sinK_d;
      cosK1_q   <= cosK_d;
    end
  end

  // ---------------- S2: table read ----------------
  logic [KW-1:0]           sinKn;
  logic [KW-1:0]           cosKn;
  logic signed [OUT_W-1:0] sinBase;
  logic signed [OUT_W-1:0] sinNext;
  logic signed [OUT_W-1:0] cosBase;
  logic signed [OUT_W-1:0] cosNext;

  logic                    valid2_q;
  logic [TAG_W-1:0]        tag2_q;
  logic                    sinNeg2_q;
  logic                    cosNeg2_q;

  // S[k+1] is clamped at the last entry; there f is always zero, so the
  // second read does not contribute.
  assign sinKn = (sinK1_q == KW'(1 << LUT_AW)) ? sinK1_q : sinK1_q + KW'(1);
  assign cosKn = (cosK1_q == KW'(1 << LUT_AW)) ? cosK1_q : cosK1_q + KW'(1);

  quarter_sin_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W),
    .HAS_B  (INTERP)
  ) u_sinRom (
    .Clk     (Clk),
    .en_i    (advance),
    .addrA_i (sinK1_q),
    .addrB_i (sinKn),
    .dataA_o (sinBase),
    .dataB_o (sinNext)
  );

  quarter_sin_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W),
    .HAS_B  (INTERP)
  ) u_cosRom (
    .Clk     (Clk),
    .en_i    (advance),
    .addrA_i (cosK1_q),
    .addrB_i (cosKn),
    .dataA_o (cosBase),
    .dataB_o (cosNext)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid2_q <= 1'b0;
    end else if (advance) begin
      valid2_q <= valid1_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (advance) begin
      tag2_q    <= tag1_q;
      sinNeg2_q <= sinNeg1_q;
      cosNeg2_q <= cosNeg1_q;
    end
  end

  // ---------------- S3: interpolate / negate ----------------
  logic signed [OUT_W-1:0] sinY;
  logic signed [OUT_W-1:0] cosY;
  logic signed [OUT_W-1:0] sinRes_d;
  logic signed [OUT_W-1:0] cosRes_d;

  logic                    outValid_q;
  logic [TAG_W-1:0]        outTag_q;
  logic signed [OUT_W-1:0] outSin_q;
  logic signed [OUT_W-1:0] outCos_q;

`ifdef TRIG_INTERP_EN
  localparam int                    PW  = OUT_W + FW + 2;
  localparam logic signed [PW-1:0]  RND = (F > 0) ? PW'(1 << (F - 1)) : '0;

  logic [FW-1:0] sinF1_q;
  logic [FW-1:0] cosF1_q;
  logic [FW-1:0] sinF2_q;
  logic [FW-1:0] cosF2_q;

  always_ff @(posedge Clk) begin
    if (advance) begin
      sinF1_q <= sinF_d;
      cosF1_q <= cosF_d;
      sinF2_q <= sinF1_q;
      cosF2_q <= cosF1_q;
    end
  end

  // y = S[k] + ((S[k+1]-S[k])*f + 2^(F-1)) >>> F with a full-width product.
  // With F = 0 the fraction is forced to zero and RND is zero, giving S[k].
  function automatic logic signed [OUT_W-1:0] interpolate(
    input logic signed [OUT_W-1:0] s0,
    input logic signed [OUT_W-1:0] s1,
    input logic [FW-1:0]           f
  );
    logic signed [OUT_W:0]  diff;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   step;
    diff = {s1[OUT_W-1], s1} - {s0[OUT_W-1], s0};
    prod = $signed({{(PW - OUT_W - 1){diff[OUT_W]}}, diff})
         * $signed({{(PW - FW){1'b0}}, f});
    step = (prod + RND) >>> F;
    return s0 + step[OUT_W-1:0];
  endfunction

  assign sinY = interpolate(sinBase, sinNext, sinF2_q);
  assign cosY = interpolate(cosBase, cosNext, cosF2_q);
`else
  assign sinY = sinBase;
  assign cosY = cosBase;
`endif

  // Folded values are never negative, so negation cannot overflow (-1.0 fits).
  always_comb begin
    sinRes_d = sinY;
    cosRes_d = cosY;
    if (sinNeg2_q) begin
      sinRes_d = -sinY;
    end
    if (cosNeg2_q) begin
      cosRes_d = -cosY;
    end
  end

  // Output register: fully reset, holds while the consumer stalls.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      outValid_q <= 1'b0;
      outTag_q   <= '0;
      outSin_q   <= '0;
      outCos_q   <= '0;
    end else if (advance) begin
      outValid_q <= valid2_q;
      outTag_q   <= tag2_q;
      outSin_q   <= sinRes_d;
      outCos_q   <= cosRes_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_tag   = outTag_q;
  assign out_sin   = outSin_q;
  assign out_cos   = outCos_q;

endmodule
